// File: rtl/masked_rand_source.sv
// -----------------------------------------------------------------------------
// masked_rand_source
//
// Randomness source for a masked (d-share) multiplier. A 64-bit Fibonacci
// LFSR is advanced RAND_BITS steps per cycle; the output bits of one such
// "advance" form a randomness word that is split into the blinding values
// R_{i,j} (out_r) and the correction values P_{i,j} (out_p).
//
// After a seed is loaded the LFSR runs WARMUP_CYCLES advances on its own
// before the first word is offered. In RUN the current word is held until
// the consumer takes it with in_next, so every word is consumed once.
//
// Ports
//   in_clock      : clock, all state changes on the rising edge
//   in_reset      : synchronous reset, active low
//   in_seed       : 64-bit LFSR seed (zero is replaced by 1)
//   in_seed_valid : load in_seed this cycle (any state)
//   in_next       : consumer took the current word, advance to the next one
//   out_r         : NUM_QUAD x BIT_WIDTH blinding randomness
//   out_p         : NUM_QUAD x BIT_WIDTH correction randomness
//   out_valid     : out_r/out_p hold fresh, unconsumed randomness
//   out_seeded    : a seed has been loaded since reset
// -----------------------------------------------------------------------------
module masked_rand_source #(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 1,
  parameter int WARMUP_CYCLES = 8,
  localparam int NUM_QUAD     = NUM_SHARES * (NUM_SHARES - 1) / 2,
  localparam int HALF_BITS    = NUM_QUAD * BIT_WIDTH,
  localparam int RAND_BITS    = 2 * HALF_BITS
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic [63:0]          in_seed,
  input  logic                 in_seed_valid,
  input  logic                 in_next,
  output logic [HALF_BITS-1:0] out_r,
  output logic [HALF_BITS-1:0] out_p,
  output logic                 out_valid,
  output logic                 out_seeded
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (NUM_SHARES < 2) begin : g_bad_shares
      $error("masked_rand_source: NUM_SHARES must be >= 2");
    end
    if (WARMUP_CYCLES < 1) begin : g_bad_warmup
      $error("masked_rand_source: WARMUP_CYCLES must be >= 1");
    end
    if (RAND_BITS > 64) begin : g_bad_width
      $error("masked_rand_source: RAND_BITS must be <= 64");
    end
  endgenerate

  // Counter only has to reach WARMUP_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARMUP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [63:0]          lfsr;
  logic [RAND_BITS-1:0] word;
  logic [CNT_W-1:0]     warm_cnt;

  logic [63:0]          lfsr_adv;
  logic [RAND_BITS-1:0] word_adv;
  logic                 cnt_last;
  logic                 do_advance;
  logic [63:0]          seed_eff;

  assign cnt_last = (warm_cnt == CNT_LAST);

  // An all-zero state would lock the LFSR at zero forever.
  assign seed_eff = (in_seed == 64'd0) ? 64'd1 : in_seed;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others; blocking here would create order-
  // dependent simulation and mismatch against synthesis.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. A seed load restarts warm-up from any state.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    if (in_seed_valid) begin
      state_next = ST_WARMUP;
    end else begin
      unique case (state)
        ST_IDLE:   state_next = ST_IDLE;
        ST_WARMUP: if (cnt_last) state_next = ST_RUN;
        ST_RUN:    state_next = ST_RUN;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid  = (state == ST_RUN);
    out_seeded = (state != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Advance control: warm-up advances every cycle, RUN only on a handshake.
  // A seed load in the same cycle wins over any advance.
  // ---------------------------------------------------------------------------
  always_comb begin
    do_advance = 1'b0;
    if (!in_seed_valid) begin
      do_advance = (state == ST_WARMUP) || ((state == ST_RUN) && in_next);
    end
  end

  // ---------------------------------------------------------------------------
  // Unrolled LFSR: RAND_BITS single steps chained within one cycle.
  // Step k feeds back s[63]^s[62]^s[60]^s[59] and that bit becomes word[k].
  // ---------------------------------------------------------------------------
  always_comb begin
    logic fb;
    lfsr_adv = lfsr;
    word_adv = '0;
    fb       = 1'b0;
    for (int k = 0; k < RAND_BITS; k++) begin
      fb          = lfsr_adv[63] ^ lfsr_adv[62] ^ lfsr_adv[60] ^ lfsr_adv[59];
      word_adv[k] = fb;
      lfsr_adv    = {lfsr_adv[62:0], fb};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the output word is reset along with the LFSR so that no stale
  // randomness from a previous session is visible on out_r/out_p after reset.
  always_ff @(posedge in_clock) begin
    if (!in_reset) begin
      lfsr     <= 64'd0;
      word     <= '0;
      warm_cnt <= '0;
    end else if (in_seed_valid) begin
      lfsr     <= seed_eff;
      warm_cnt <= '0;
    end else if (do_advance) begin
      lfsr <= lfsr_adv;
      word <= word_adv;
      if ((state == ST_WARMUP) && !cnt_last) begin
        warm_cnt <= warm_cnt + 1'b1;
      end
    end
  end

  // Lower half carries R, upper half carries P; element i sits at
  // bits [i*BIT_WIDTH +: BIT_WIDTH] of each half.
  assign out_r = word[HALF_BITS-1:0];
  assign out_p = word[RAND_BITS-1:HALF_BITS];

endmodule

// File: tb/tb_masked_rand_source.sv
// -----------------------------------------------------------------------------
// tb_masked_rand_source
//
// Two instances (2 shares and 3 shares) share one set of drivers. The
// reference model regards the LFSR as a bit sequence u[t] obeying
// u[t] = u[t-64]^u[t-63]^u[t-61]^u[t-60], with the seed supplying the 64
// bits before t=0; each word is the next RAND_BITS bits of that sequence.
// Expected words go into a queue; a monitor compares whenever the selected
// instance shows out_valid and pops on each accepted handshake.
// -----------------------------------------------------------------------------
module tb_masked_rand_source;

  localparam int WARM = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] seed;
  logic        seed_valid;
  logic        next;

  logic [0:0]  a_r, a_p;
  logic        a_valid, a_seeded;
  logic [2:0]  b_r, b_p;
  logic        b_valid, b_seeded;

  int          errors = 0;
  int          checks = 0;
  bit          sel = 1'b0;      // 0: watch 2-share instance, 1: 3-share
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  masked_rand_source #(.NUM_SHARES(2), .BIT_WIDTH(1), .WARMUP_CYCLES(WARM)) u_dut2 (
    .in_clock(clk), .in_reset(rst_n), .in_seed(seed), .in_seed_valid(seed_valid),
    .in_next(next), .out_r(a_r), .out_p(a_p), .out_valid(a_valid), .out_seeded(a_seeded)
  );

  masked_rand_source #(.NUM_SHARES(3), .BIT_WIDTH(1), .WARMUP_CYCLES(WARM)) u_dut3 (
    .in_clock(clk), .in_reset(rst_n), .in_seed(seed), .in_seed_valid(seed_valid),
    .in_next(next), .out_r(b_r), .out_p(b_p), .out_valid(b_valid), .out_seeded(b_seeded)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mon_word();
    return sel ? 64'({b_p, b_r}) : 64'({a_p, a_r});
  endfunction

  function automatic logic mon_valid();
    return sel ? b_valid : a_valid;
  endfunction

  // Append n expected words (the ones presented after warm-up) for a seed.
  task automatic push_words(input logic [63:0] sd, input int rb, input int n);
    bit          seq[$];
    logic [63:0] s0;
    logic [63:0] w;
    int          total;
    s0 = (sd == 64'd0) ? 64'd1 : sd;
    for (int j = 63; j >= 0; j--) seq.push_back(s0[j]);
    total = (WARM - 1 + n) * rb;
    for (int i = 0; i < total; i++) begin
      int m;
      m = seq.size();
      seq.push_back(seq[m-64] ^ seq[m-63] ^ seq[m-61] ^ seq[m-60]);
    end
    // Warm-up performs WARM advances; the last of them is the first word shown.
    for (int wi = WARM - 1; wi < WARM - 1 + n; wi++) begin
      w = '0;
      for (int k = 0; k < rb; k++) w[k] = seq[64 + wi*rb + k];
      exp_q.push_back(w);
    end
  endtask

  // Scoreboard monitor: sample on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mon_valid()) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got %h expected nothing (queue empty) at %0t",
                   mon_word(), $time);
        end else begin
          check("word", mon_word(), exp_q[0]);
          if (next && !seed_valid) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle seed pulse; afterwards the queue holds the new expectations.
  task automatic load_seed(input logic [63:0] sd, input logic [63:0] model_sd,
                           input int rb, input int n);
    seed       = sd;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    exp_q.delete();
    push_words(model_sd, rb, n);
  endtask

  // Called right after a load: valid stays low 8 cycles, then rises.
  task automatic check_warmup(input string name);
    for (int i = 0; i < WARM; i++) begin
      check({name, "_valid_low"}, 64'(mon_valid()), 64'd0);
      tick();
    end
    check({name, "_valid_high"}, 64'(mon_valid()), 64'd1);
  endtask

  // Continuous handshakes on the 2-share instance with the known seed-1 points.
  task automatic run_known_sequence(input string name);
    next = 1'b1;
    for (int h = 1; h <= 25; h++) begin
      tick();
      if (h == 22) check({name, "_hs22_pr"}, 64'({a_p, a_r}), 64'b10);
      if (h == 23) check({name, "_hs23_pr"}, 64'({a_p, a_r}), 64'b01);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    seed       = 64'd0;
    seed_valid = 1'b0;
    next       = 1'b0;
    tick();
    // Reset has priority over a seed load in the same cycle.
    seed       = 64'h1234;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    check("reset_state", 64'({a_valid, a_seeded, a_p, a_r}), 64'd0);
    check("reset_over_seed", 64'(b_seeded), 64'd0);

    // No seed: in_next has no effect, everything stays zero.
    rst_n = 1'b1;
    next  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", 64'({a_valid, a_seeded, a_p, a_r}), 64'd0);
    end

    // Seed 1, no consumer: valid after 8 cycles, word zero and held.
    next = 1'b0;
    load_seed(64'h1, 64'h1, 2, 60);
    check("seeded_after_load", 64'(a_seeded), 64'd1);
    check_warmup("seed1");
    check("seed1_first_word", 64'({a_p, a_r}), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 64'(a_valid), 64'd1);
    end

    // Five handshakes, then reseed mid-RUN; sequence must restart.
    next = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    load_seed(64'h1, 64'h1, 2, 60);
    check_warmup("reseed");
    run_known_sequence("reseed");

    // Zero seed behaves exactly like seed 1.
    load_seed(64'h0, 64'h1, 2, 60);
    check_warmup("seed0");
    run_known_sequence("seed0");

    // Reset mid-RUN clears everything.
    rst_n = 1'b0;
    tick();
    check("reset_mid_run", 64'({a_valid, a_seeded, a_p, a_r}), 64'd0);
    rst_n = 1'b1;
    next  = 1'b0;
    tick();

    // Three shares: random seeds, random consumer.
    sel = 1'b1;
    for (int s = 0; s < 3; s++) begin
      logic [63:0] sd;
      sd = {$urandom(), $urandom()};
      load_seed(sd, sd, 6, 300);
      check("ns3_seeded", 64'(b_seeded), 64'd1);
      for (int c = 0; c < 120; c++) begin
        next = 1'($urandom_range(0, 1));
        tick();
      end
    end

    // Reset during warm-up: all outputs back to zero, no recovery without seed.
    next = 1'b0;
    load_seed({$urandom(), $urandom()}, 64'h1, 6, 1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("ns3_reset_mid_warmup", 64'({b_valid, b_seeded, b_p, b_r}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < WARM + 2; i++) tick();
    check("ns3_stays_idle", 64'({b_valid, b_seeded, b_p, b_r}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/masked_rand_source.md
MASKED_RAND_SOURCE -- requirements
Module: masked_rand_source

Interface
REQ-001 Parameter NUM_SHARES, default 2, number of shares of the masked multiplier being fed; SHALL be >= 2.
REQ-002 Parameter BIT_WIDTH, default 1, width of one random element.
REQ-003 Parameter WARMUP_CYCLES, default 8, number of LFSR advance cycles after seeding before output is valid; SHALL be >= 1.
REQ-004 Derived NUM_QUAD = NUM_SHARES*(NUM_SHARES-1)/2 and RAND_BITS = 2*NUM_QUAD*BIT_WIDTH; RAND_BITS SHALL be <= 64 (elaboration error otherwise).
REQ-005 in_clock  input  1  single clock; all state updates on its rising edge.
REQ-006 in_reset  input  1  synchronous, active-low reset.
REQ-007 in_seed  input  64  LFSR seed value.
REQ-008 in_seed_valid  input  1  load in_seed this cycle.
REQ-009 in_next  input  1  consumer has taken the current randomness; request the next word.
REQ-010 out_r  output  NUM_QUAD x BIT_WIDTH  blinding randomness (R_{i,j}) for the masked multiplier.
REQ-011 out_p  output  NUM_QUAD x BIT_WIDTH  correction randomness (P_{i,j}) for the masked multiplier.
REQ-012 out_valid  output  1  out_r/out_p hold fresh, unconsumed randomness.
REQ-013 out_seeded  output  1  a seed has been loaded since reset (state != IDLE).

Function
REQ-014 The block SHALL hold a 64-bit state s, a RAND_BITS output register q, a warm-up counter, and an FSM with states IDLE, WARMUP, RUN.
REQ-015 Single LFSR step: f = s[63]^s[62]^s[60]^s[59]; s <= {s[62:0], f}; f is the step's output bit.
REQ-016 One "advance" SHALL apply RAND_BITS consecutive steps in one cycle; q[k] SHALL be the output bit of the k-th step (k=0 first).
REQ-017 Mapping: out_r = q[NUM_QUAD*BIT_WIDTH-1:0], out_p = q[RAND_BITS-1:NUM_QUAD*BIT_WIDTH], element index i at bits [i*BIT_WIDTH +: BIT_WIDTH] of each half.
REQ-018 Seed load: when in_seed_valid=1, s <= (in_seed==0 ? 64'h1 : in_seed), counter <= 0, q unchanged, FSM -> WARMUP, in any state; seed load overrides any advance in the same cycle.
REQ-019 IDLE: no advance; out_valid=0; in_next ignored.
REQ-020 WARMUP: one advance per cycle regardless of in_next; counter increments; the cycle with counter == WARMUP_CYCLES-1 SHALL transition to RUN.
REQ-021 RUN: out_valid=1; advance exactly when in_next=1; otherwise s and q hold (outputs stable until consumed).
REQ-022 out_valid SHALL be 0 in the cycle following any seed load and for WARMUP_CYCLES cycles total, becoming 1 in the cycle after the last WARMUP advance.
REQ-023 in_next while out_valid=0 SHALL have no effect.
REQ-024 out_valid and out_seeded SHALL be decoded from registered FSM state only (no combinational path from inputs).
REQ-025 No randomness word SHALL be presented with out_valid=1 for more than one accepted handshake; each accepted word differs in LFSR position from all others since the last seed.

Reset
REQ-026 While in_reset=0 at a clock edge: FSM <= IDLE, s <= 0, q <= 0, counter <= 0; out_r=0, out_p=0, out_valid=0, out_seeded=0 from the next cycle.
REQ-027 Reset SHALL take priority over in_seed_valid and in_next; reset mid-WARMUP or mid-RUN SHALL discard all state and require a new seed.

Verification (NUM_SHARES=2, BIT_WIDTH=1, WARMUP_CYCLES=8 unless stated)
REQ-028 Reset, then in_next=1 for 20 cycles without seed -> out_valid=0, out_seeded=0, out_r=out_p=0 throughout.
REQ-029 Seed 64'h1, in_next=0 -> out_valid rises exactly 8 cycles after the load cycle with out_r=0, out_p=0, and outputs hold while in_next=0.
REQ-030 Seed 64'h1, in_next=1 continuously in RUN -> handshakes 1..21 give out_r=0,out_p=0; handshake 22 gives out_r=0,out_p=1; handshake 23 gives out_r=1,out_p=0.
REQ-031 Seed 64'h0 -> bit-identical output sequence to seed 64'h1.
REQ-032 Reseed with 64'h1 during RUN after 5 handshakes -> out_valid=0 next cycle for 8 cycles, then sequence restarts identically to REQ-030.
REQ-033 NUM_SHARES=3, random seed, random in_next -> each accepted word equals a software model of REQ-015..017 (6 bits per advance); in_reset=0 mid-WARMUP returns all outputs to 0 next cycle.
